// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-dump scanner: state encoding, data widths
// and a half-word select helper.
package reg_dump_pkg;

  localparam int DISP_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    SHOW_LO = 2'd2,
    SHOW_HI = 2'd3
  } state_t;

  // Selects the low (hi=0) or high (hi=1) half-word of a register value.
  function automatic logic [DISP_W-1:0] select_half(input logic [DATA_W-1:0] word,
                                                    input logic hi);
    return hi ? word[DATA_W-1:DISP_W] : word[DISP_W-1:0];
  endfunction

endpackage

// File: rtl/reg_dump_scanner_dwell_timer.sv
// Dwell timer for the register-dump scanner: counts enabled cycles up to
// DWELL_CYCLES-1 and flags the terminal count. A forced terminal count
// (manual stepping) behaves exactly like a natural one.
module dwell_timer #(
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic force_tc,
  output logic tc
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign tc = force_tc | (enable & (count == LAST));

  // Count enabled cycles; restart from zero on clear or at each terminal count
  // so the value never passes DWELL_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      count <= '0;
    end else if (clear || tc) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_dump_scanner.sv
// Register-dump scanner: walks register addresses 0..NUM_REGS-1, snapshots each
// value into a shadow register and shows it on the 16-bit display, low half then
// high half, each for DWELL_CYCLES cycles.
// Optional feature macro REG_DUMP_STEP_EN: adds a 'step' input; while pause is
// high each rising edge of step advances one half-word.
module reg_dump_scanner
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int DWELL_CYCLES = 50000000,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
`ifdef REG_DUMP_STEP_EN
  input  logic              step,
`endif
  input  logic [DATA_W-1:0] reg_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DISP_W-1:0] display_output,
  output logic [ADDR_W-1:0] shown_reg,
  output logic              half_hi,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] shadow;
  logic              in_show;
  logic              tc;
  logic              force_tc;

  assign in_show = (state == SHOW_LO) || (state == SHOW_HI);

`ifdef REG_DUMP_STEP_EN
  logic step_q;

  // Remember the previous step level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 1'b0;
    else     step_q <= step;
  end

  // A step edge only counts while the timer is frozen by pause.
  assign force_tc = in_show & pause & step & ~step_q;
`else
  assign force_tc = 1'b0;
`endif

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (~in_show),
    .enable  (in_show & ~pause),
    .force_tc(force_tc),
    .tc      (tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort wins over start and over a terminal count.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = FETCH;
        FETCH:   state_next = SHOW_LO;
        SHOW_LO: if (tc) state_next = SHOW_HI;
        SHOW_HI: if (tc) state_next = (reg_addr == LAST_ADDR) ? IDLE : FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != IDLE);
  end

  // Address counter, shadow snapshot, display registers and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the shadow register is cleared by reset along with the rest, so the
    // display path never exposes an undefined value after power-up.
    if (rst) begin
      reg_addr       <= '0;
      shadow         <= '0;
      display_output <= '0;
      shown_reg      <= '0;
      half_hi        <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        reg_addr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) reg_addr <= '0;
          end
          FETCH: begin
            shadow         <= reg_data;
            display_output <= select_half(reg_data, 1'b0);
            shown_reg      <= reg_addr;
            half_hi        <= 1'b0;
          end
          SHOW_LO: begin
            if (tc) begin
              // Flip to the other half of the snapshot taken in FETCH.
              display_output <= select_half(shadow, ~half_hi);
              half_hi        <= 1'b1;
            end
          end
          SHOW_HI: begin
            if (tc) begin
              if (reg_addr == LAST_ADDR) begin
                done     <= 1'b1;
                reg_addr <= '0;
              end else begin
                reg_addr <= reg_addr + ADDR_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed bench for reg_dump_scanner with NUM_REGS=4, DWELL_CYCLES=3 and a
// register-bank model returning 32'hA5A5_0000 + addr.
module tb_reg_dump_scanner;

  localparam int NR = 4;
  localparam int DW = 3;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          pause;
`ifdef REG_DUMP_STEP_EN
  logic          step;
`endif
  logic [31:0]   reg_data;
  logic [AW-1:0] reg_addr;
  logic [15:0]   display_output;
  logic [AW-1:0] shown_reg;
  logic          half_hi;
  logic          busy;
  logic          done;

  logic [31:0]   bank [0:31];

  int n_checks = 0;
  int n_fail   = 0;

  assign reg_data = bank[reg_addr];

  always #5 clk = ~clk;

  reg_dump_scanner #(
    .NUM_REGS    (NR),
    .DWELL_CYCLES(DW),
    .ADDR_W      (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .pause         (pause),
`ifdef REG_DUMP_STEP_EN
    .step          (step),
`endif
    .reg_data      (reg_data),
    .reg_addr      (reg_addr),
    .display_output(display_output),
    .shown_reg     (shown_reg),
    .half_hi       (half_hi),
    .busy          (busy),
    .done          (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge and settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge (edge N); returns 1 unit after edge N.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) check("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_disp"},  {16'b0, display_output}, 32'h0);
    check({tag, "_addr"},  {27'b0, reg_addr},       32'h0);
    check({tag, "_shown"}, {27'b0, shown_reg},      32'h0);
    check({tag, "_half"},  {31'b0, half_hi},        32'h0);
    check({tag, "_busy"},  {31'b0, busy},           32'h0);
    check({tag, "_done"},  {31'b0, done},           32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, m, dc, lo1, ndone;
    logic [15:0] exp_disp;

    for (int i = 0; i < 32; i++) bank[i] = 32'hA5A5_0000 + i;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
`ifdef REG_DUMP_STEP_EN
    step = 1'b0;
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Full scan; a start pulse mid-scan must be ignored.
    pulse_start();
    check("scan_busy_c0", {31'b0, busy}, 32'd1);
    for (int c = 1; c <= 28; c++) begin
      tick();
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      k = (c - 1) / 7;
      m = (c - 1) % 7;
      exp_disp = (m < 3) ? 16'(k) : 16'hA5A5;
      check($sformatf("scan_disp_c%0d", c),  {16'b0, display_output}, {16'b0, exp_disp});
      check($sformatf("scan_half_c%0d", c),  {31'b0, half_hi},        (m >= 3) ? 32'd1 : 32'd0);
      check($sformatf("scan_shown_c%0d", c), {27'b0, shown_reg},      32'(k));
      check($sformatf("scan_busy_c%0d", c),  {31'b0, busy},           (c < 28) ? 32'd1 : 32'd0);
      check($sformatf("scan_done_c%0d", c),  {31'b0, done},           (c == 28) ? 32'd1 : 32'd0);
    end
    tick();
    check("scan_done_single", {31'b0, done}, 32'd0);
    check("scan_idle_busy",   {31'b0, busy}, 32'd0);

    // Pause for 5 cycles in SHOW_LO of register 1.
    pulse_start();
    lo1 = 0;
    dc  = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 9)  pause = 1'b1;
      if (c == 14) pause = 1'b0;
      if (display_output == 16'h0001 && shown_reg == 5'd1 && !half_hi) lo1++;
      if (done) begin
        dc = c;
        break;
      end
    end
    check("pause_hold_cycles", 32'(lo1), 32'd8);
    check("pause_done_cycle",  32'(dc),  32'd33);

    // Abort in SHOW_HI of register 2.
    tick();
    pulse_start();
    repeat (18) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",  {31'b0, busy},           32'd0);
    check("abort_done",  {31'b0, done},           32'd0);
    check("abort_disp",  {16'b0, display_output}, 32'h0000_A5A5);
    check("abort_shown", {27'b0, shown_reg},      32'd2);
    check("abort_half",  {31'b0, half_hi},        32'd1);
    check("abort_addr",  {27'b0, reg_addr},       32'd0);
    // Abort beats start in IDLE.
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_over_start", {31'b0, busy}, 32'd0);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // Start held high: done after 28 cycles, then an immediate restart.
    start = 1'b1;
    wait_done(60, dc);
    check("held_start_done_cycle", 32'(dc), 32'd29);
    tick();
    check("held_start_restart", {31'b0, busy}, 32'd1);
    start = 1'b0;
    go_idle();

    // Shadow isolation: bank write mid-SHOW_LO of register 1.
    pulse_start();
    repeat (9) tick();
    bank[1] = 32'h1234_5678;
    repeat (2) tick();
    check("shadow_hi_disp",  {16'b0, display_output}, 32'h0000_A5A5);
    check("shadow_hi_shown", {27'b0, shown_reg},      32'd1);
    wait_done(40, dc);
    check("shadow_done_cycle", 32'(dc), 32'd17);
    pulse_start();
    repeat (8) tick();
    check("rescan_lo", {16'b0, display_output}, 32'h0000_5678);
    repeat (3) tick();
    check("rescan_hi", {16'b0, display_output}, 32'h0000_1234);
    go_idle();
    bank[1] = 32'hA5A5_0001;

    // Asynchronous reset in the middle of a SHOW_HI cycle.
    pulse_start();
    repeat (4) tick();
    check("pre_reset_half", {31'b0, half_hi}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      tick();
      if (done || busy) ndone++;
    end
    check("post_reset_idle", 32'(ndone), 32'd0);

`ifdef REG_DUMP_STEP_EN
    // Manual stepping while paused.
    pause = 1'b1;
    pulse_start();
    tick();
    check("step_disp0", {16'b0, display_output}, 32'h0000_0000);
    repeat (5) tick();
    check("step_hold0", {16'b0, display_output}, 32'h0000_0000);
    check("step_half0", {31'b0, half_hi},        32'd0);
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    check("step_disp1", {16'b0, display_output}, 32'h0000_A5A5);
    repeat (3) tick();
    check("step_hold1", {16'b0, display_output}, 32'h0000_A5A5);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (3) tick();
    check("step_disp2",  {16'b0, display_output}, 32'h0000_0001);
    check("step_shown2", {27'b0, shown_reg},      32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("step_disp3", {16'b0, display_output}, 32'h0000_A5A5);
    go_idle();
    pause = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
